// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
// Shares one sprite pattern ROM port between NREQ sprite pixel engines.
// Round-robin arbitration, one registered ROM access per cycle, responses
// returned tagged with the requester id at a fixed latency of ROM_LAT+2.
//
// Optional feature macro: SPRITE_ARB_LOCK_EN
//   Adds req_lock; a locked accept starts a burst of up to 32 grants
//   during which the locked requester keeps priority.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   hold                  suppress new grants this cycle
//   req/req_addr/req_img  per-requester request, packed address, image select
//   req_lock              (SPRITE_ARB_LOCK_EN only) burst lock request
//   gnt                   combinational one-hot grant
//   rom_en/rom_addr/rom_img  registered ROM read strobe, address, image select
//   rom_q                 ROM data, valid ROM_LAT cycles after rom_en
//   rsp_valid/rsp_id/rsp_data/rsp_bad  registered tagged response
//   busy                  any access in flight
module sprite_rom_arbiter #(
   parameter int unsigned NREQ    = 3,
   parameter int unsigned AW      = 10,
   parameter int unsigned IMGW    = 5,
   parameter int unsigned NIMG    = 3,
   parameter int unsigned DW      = 4,
   parameter int unsigned ROM_LAT = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     hold,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*AW-1:0]       req_addr,
   input  logic [NREQ*IMGW-1:0]     req_img,
`ifdef SPRITE_ARB_LOCK_EN
   input  logic [NREQ-1:0]          req_lock,
`endif
   output logic [NREQ-1:0]          gnt,
   output logic                     rom_en,
   output logic [AW-1:0]            rom_addr,
   output logic [IMGW-1:0]          rom_img,
   input  logic [DW-1:0]            rom_q,
   output logic                     rsp_valid,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [DW-1:0]            rsp_data,
   output logic                     rsp_bad,
   output logic                     busy
);

   localparam int unsigned IDW  = $clog2(NREQ);
   localparam int unsigned NSTG = ROM_LAT + 1;

   logic [IDW-1:0]   ptr;
   logic             accept;
   logic [IDW-1:0]   win_id;
   logic [IDW-1:0]   idx;
   logic [AW-1:0]    win_addr;
   logic [IMGW-1:0]  win_img;
   logic             win_bad;

   // Tag pipeline {valid, id, bad}; stage 0 lines up with rom_en,
   // the last stage lines up with valid rom_q.
   logic [NSTG-1:0]  tag_v;
   logic [IDW-1:0]   tag_id [NSTG];
   logic [NSTG-1:0]  tag_bad;

`ifdef SPRITE_ARB_LOCK_EN
   logic             lock_act;
   logic [IDW-1:0]   lock_id;
   logic [4:0]       lock_cnt;
   logic             lock_grant;
`endif

   // Grant selection: burst owner first (when locking), else round-robin after ptr.
   always_comb begin
      gnt    = '0;
      accept = 1'b0;
      win_id = ptr;
      idx    = '0;
`ifdef SPRITE_ARB_LOCK_EN
      lock_grant = 1'b0;
`endif
      if (!hold) begin
`ifdef SPRITE_ARB_LOCK_EN
         if (lock_act && req[lock_id] && req_lock[lock_id]) begin
            lock_grant = 1'b1;
            accept     = 1'b1;
            win_id     = lock_id;
         end
`endif
         for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDW'((32'(ptr) + k) % NREQ);
            if (!accept && req[idx]) begin
               accept = 1'b1;
               win_id = idx;
            end
         end
      end
      if (accept) gnt[win_id] = 1'b1;
   end

   assign win_addr = req_addr[32'(win_id)*AW +: AW];
   assign win_img  = req_img[32'(win_id)*IMGW +: IMGW];
   assign win_bad  = (32'(win_img) >= NIMG);

   // ROM issue, tag pipeline and response registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr       <= IDW'(NREQ - 1);
         rom_en    <= 1'b0;
         rom_addr  <= '0;
         rom_img   <= '0;
         tag_v     <= '0;
         tag_bad   <= '0;
         for (int unsigned s = 0; s < NSTG; s++) tag_id[s] <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_bad   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (accept) begin
            ptr      <= win_id;
            rom_addr <= win_addr;
            rom_img  <= win_img;
         end
         rom_en     <= accept;
         tag_v[0]   <= accept;
         tag_id[0]  <= win_id;
         tag_bad[0] <= win_bad;
         for (int unsigned s = 1; s < NSTG; s++) begin
            tag_v[s]   <= tag_v[s-1];
            tag_id[s]  <= tag_id[s-1];
            tag_bad[s] <= tag_bad[s-1];
         end
         rsp_valid <= tag_v[NSTG-1];
         if (tag_v[NSTG-1]) begin
            rsp_id   <= tag_id[NSTG-1];
            rsp_data <= tag_bad[NSTG-1] ? '0 : rom_q;
            rsp_bad  <= tag_bad[NSTG-1];
         end
         // Next-cycle value of rom_en | all tag valids.
         busy <= accept | (|tag_v[NSTG-2:0]);
      end
   end

`ifdef SPRITE_ARB_LOCK_EN
   // Burst tracking; ptr already equals the owner after each burst grant,
   // so round-robin resumes after it when the burst ends.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_act <= 1'b0;
         lock_id  <= '0;
         lock_cnt <= '0;
      end else if (lock_grant) begin
         if (lock_cnt == 5'd31) lock_act <= 1'b0;
         else                   lock_cnt <= lock_cnt + 5'd1;
      end else if (accept && req_lock[win_id]) begin
         lock_act <= 1'b1;
         lock_id  <= win_id;
         lock_cnt <= 5'd1;
      end else if (!hold) begin
         lock_act <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed self-checking bench for sprite_rom_arbiter (default parameters).
module tb_sprite_rom_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        hold;
   logic [2:0]  req;
   logic [29:0] req_addr;
   logic [14:0] req_img;
`ifdef SPRITE_ARB_LOCK_EN
   logic [2:0]  req_lock;
`endif
   logic [2:0]  gnt;
   logic        rom_en;
   logic [9:0]  rom_addr;
   logic [4:0]  rom_img;
   logic [3:0]  rom_q;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [3:0]  rsp_data;
   logic        rsp_bad;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   sprite_rom_arbiter dut (
      .clk(clk), .reset_n(reset_n), .hold(hold), .req(req),
      .req_addr(req_addr), .req_img(req_img),
`ifdef SPRITE_ARB_LOCK_EN
      .req_lock(req_lock),
`endif
      .gnt(gnt), .rom_en(rom_en), .rom_addr(rom_addr), .rom_img(rom_img),
      .rom_q(rom_q), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_bad(rsp_bad), .busy(busy)
   );

   always #5 clk = ~clk;

   // ROM model, one cycle latency: returns the low address nibble.
   always @(posedge clk) rom_q <= rom_addr[3:0];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      hold     = 1'b0;
      req      = '0;
      req_addr = '0;
      req_img  = '0;
`ifdef SPRITE_ARB_LOCK_EN
      req_lock = '0;
`endif
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic set_req(input int i, input logic [9:0] a, input logic [4:0] img);
      req_addr[i*10 +: 10] = a;
      req_img[i*5 +: 5]    = img;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      hold = 1'b0; req = '0; req_addr = '0; req_img = '0;
`ifdef SPRITE_ARB_LOCK_EN
      req_lock = '0;
`endif
      #1;
      n_tests++;
      if ({rom_en, rom_addr, rom_img, rsp_valid, rsp_id, rsp_data, rsp_bad, busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got en=%b addr=%0d img=%0d v=%b id=%0d d=%0d bad=%b busy=%b exp all 0",
                  rom_en, rom_addr, rom_img, rsp_valid, rsp_id, rsp_data, rsp_bad, busy);
      end
      n_tests++;
      if (gnt !== 3'b000) begin
         n_fail++; $display("FAIL reset_gnt got=%b exp=000", gnt);
      end
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_round_robin();
      int id;
      do_reset();
      set_req(0, 10'd5, 5'd0);
      set_req(1, 10'd6, 5'd0);
      set_req(2, 10'd7, 5'd0);
      req = 3'b111;
      #1;
      for (int c = 0; c < 9; c++) begin
         n_tests++;
         if (gnt !== 3'(1 << (c % 3))) begin
            n_fail++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, 3'(1 << (c % 3)));
         end
         n_tests++;
         if (rom_en !== (c >= 1)) begin
            n_fail++; $display("FAIL rr_rom_en c=%0d got=%b exp=%b", c, rom_en, c >= 1);
         end
         if (c >= 1) begin
            n_tests++;
            if (rom_addr !== 10'(5 + (c - 1) % 3)) begin
               n_fail++; $display("FAIL rr_rom_addr c=%0d got=%0d exp=%0d", c, rom_addr, 5 + (c - 1) % 3);
            end
         end
         n_tests++;
         if (rsp_valid !== (c >= 3)) begin
            n_fail++; $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, c >= 3);
         end
         if (c >= 3) begin
            id = (c - 3) % 3;
            n_tests++;
            if (rsp_id !== 2'(id) || rsp_data !== 4'(5 + id) || rsp_bad !== 1'b0) begin
               n_fail++;
               $display("FAIL rr_rsp c=%0d got id=%0d d=%0d bad=%b exp id=%0d d=%0d bad=0",
                        c, rsp_id, rsp_data, rsp_bad, id, 5 + id);
            end
         end
         step();
      end
      req = '0;
      repeat (4) step();
   endtask

   task automatic test_single();
      do_reset();
      set_req(1, 10'd33, 5'd1);
      req = 3'b010;
      #1;
      n_tests++;
      if (gnt !== 3'b010) begin n_fail++; $display("FAIL single_gnt got=%b exp=010", gnt); end
      step();
      req = '0;
      #1;
      n_tests++;
      if (rom_en !== 1'b1 || rom_addr !== 10'd33 || rom_img !== 5'd1) begin
         n_fail++; $display("FAIL single_rom got en=%b addr=%0d img=%0d exp en=1 addr=33 img=1", rom_en, rom_addr, rom_img);
      end
      n_tests++;
      if (gnt !== 3'b000) begin n_fail++; $display("FAIL single_gnt_idle got=%b exp=000", gnt); end
      step();
      n_tests++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got v=%b exp=0", rsp_valid); end
      step();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 4'h1 || rsp_bad !== 1'b0) begin
         n_fail++; $display("FAIL single_rsp got v=%b id=%0d d=%0d bad=%b exp v=1 id=1 d=1 bad=0",
                            rsp_valid, rsp_id, rsp_data, rsp_bad);
      end
      step();
      n_tests++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL single_drain got v=%b busy=%b exp 0 0", rsp_valid, busy);
      end
   endtask

   task automatic test_bad_img();
      set_req(2, 10'd47, 5'd7);
      req = 3'b100;
      #1;
      n_tests++;
      if (gnt !== 3'b100) begin n_fail++; $display("FAIL bad_gnt got=%b exp=100", gnt); end
      step();
      req = '0;
      step();
      step();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 4'h0 || rsp_bad !== 1'b1) begin
         n_fail++; $display("FAIL bad_rsp got v=%b id=%0d d=%0d bad=%b exp v=1 id=2 d=0 bad=1",
                            rsp_valid, rsp_id, rsp_data, rsp_bad);
      end
      step();
   endtask

   task automatic test_hold();
      logic [2:0] exp_g [7];
      exp_g = '{3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
      do_reset();
      set_req(0, 10'd8, 5'd0);
      set_req(2, 10'd9, 5'd0);
      req = 3'b101;
      for (int c = 0; c < 7; c++) begin
         hold = (c >= 2 && c <= 5);
         #1;
         n_tests++;
         if (gnt !== exp_g[c]) begin
            n_fail++; $display("FAIL hold_gnt c=%0d got=%b exp=%b", c, gnt, exp_g[c]);
         end
         if (c == 3 || c == 4) begin
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'((c == 3) ? 0 : 2) || rsp_data !== 4'((c == 3) ? 8 : 9)) begin
               n_fail++; $display("FAIL hold_rsp c=%0d got v=%b id=%0d d=%0d", c, rsp_valid, rsp_id, rsp_data);
            end
         end
         if (c >= 3) begin
            n_tests++;
            if (busy !== (c == 3)) begin
               n_fail++; $display("FAIL hold_busy c=%0d got=%b exp=%b", c, busy, c == 3);
            end
         end
         step();
      end
      hold = 1'b0;
      req  = '0;
      repeat (4) step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_req(1, 10'd3, 5'd0);
      req = 3'b010;
      #1;
      n_tests++;
      if (gnt !== 3'b010) begin n_fail++; $display("FAIL rmid_gnt got=%b exp=010", gnt); end
      step();
      req = '0;
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (rom_en !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rmid_clear got en=%b busy=%b exp 0 0", rom_en, busy);
      end
      step();
      step();
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         n_tests++;
         if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp c=%0d got v=%b exp=0", c, rsp_valid); end
         step();
      end
      req = 3'b111;
      #1;
      n_tests++;
      if (gnt !== 3'b001) begin n_fail++; $display("FAIL rmid_first got=%b exp=001", gnt); end
      req = '0;
      step();
   endtask

`ifdef SPRITE_ARB_LOCK_EN
   task automatic test_lock();
      // Full 32-grant burst by requester 2.
      do_reset();
      req = 3'b100;
      req_lock = 3'b100;
      for (int c = 0; c < 34; c++) begin
         #1;
         n_tests++;
         if (gnt !== ((c < 32) ? 3'b100 : ((c == 32) ? 3'b001 : 3'b010))) begin
            n_fail++; $display("FAIL lock32_gnt c=%0d got=%b", c, gnt);
         end
         step();
         req = 3'b111;
      end
      // Burst cut short by dropping req_lock after 10 grants.
      do_reset();
      req = 3'b100;
      req_lock = 3'b100;
      for (int c = 0; c < 13; c++) begin
         if (c == 10) req_lock = 3'b000;
         #1;
         n_tests++;
         if (gnt !== ((c < 10) ? 3'b100 : ((c == 10) ? 3'b001 : ((c == 11) ? 3'b010 : 3'b100)))) begin
            n_fail++; $display("FAIL lock10_gnt c=%0d got=%b", c, gnt);
         end
         step();
         req = 3'b111;
      end
      req = '0;
      req_lock = '0;
      repeat (4) step();
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_bad_img();
      test_hold();
      test_reset_mid();
`ifdef SPRITE_ARB_LOCK_EN
      test_lock();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares the sprite pattern ROMs between NREQ independent sprite pixel engines, so each engine no longer needs its own ROM port.
- Arbitrates requests round-robin and drives one registered ROM address/image-select per cycle.
- Returns the 4-bit pixel colour to the winning engine, tagged with its requester id, at a fixed latency.
- Sits between the sprite engines and the plane/chopper/battleship ROMs in the VGA peripheral.

Parameters:
- NREQ, 3, number of requesting sprite engines (2..8)
- AW, 10, ROM address width (32x32 sprite = 1024 words)
- IMGW, 5, image-select width
- NIMG, 3, number of populated images; img >= NIMG is invalid
- DW, 4, pixel colour width
- ROM_LAT, 1, cycles from rom_en/rom_addr to valid rom_q (1..3)

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous active-low reset
- hold  in  1  1 = issue no grants this cycle (driven by the blanking/config controller)
- req  in  NREQ  per-requester request, level
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_img  in  NREQ*IMGW  packed image selects
- gnt  out  NREQ  one-hot grant, combinational; req[i]&gnt[i] = accept
- rom_en  out  1  registered ROM read strobe
- rom_addr  out  AW  registered ROM address
- rom_img  out  IMGW  registered image select (ROM output mux control)
- rom_q  in  DW  muxed ROM data, valid ROM_LAT cycles after rom_en
- rsp_valid  out  1  registered response valid
- rsp_id  out  $clog2(NREQ)  requester id of the response
- rsp_data  out  DW  pixel colour
- rsp_bad  out  1  response was for an invalid image
- busy  out  1  any access in flight (rom_en or pipeline valid)

Behaviour:
- Reset (async, reset_n=0): rom_en=0, rom_addr=0, rom_img=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_bad=0, busy=0.
- Reset also clears all in-flight tags and sets the round-robin pointer to NREQ-1, so requester 0 wins first.
- Grant is combinational. If hold=1 or req=0, gnt=0.
- Otherwise gnt is the first set req bit searching ptr+1, ptr+2, ... modulo NREQ.
- At most one accept per cycle. ptr <= granted index on accept only; no accept leaves ptr unchanged.
- Cycle T accept:
  - T+1: rom_en=1, rom_addr/rom_img = winner's inputs from T.
  - T+1+ROM_LAT: rom_q is sampled.
  - T+2+ROM_LAT: rsp_valid=1, rsp_id=winner, rsp_data=rom_q.
  - Total fixed latency ROM_LAT+2 (3 at default). Full throughput: one access per cycle, back-to-back.
- Tag pipeline is ROM_LAT+1 stages of {valid, id, bad}. No backpressure: requesters must consume rsp in the cycle it is valid.
- Invalid image (req_img >= NIMG): still granted and issued. The response carries rsp_data=0 (transparent) and rsp_bad=1.
- Requester withdraws req in a cycle with no grant: no state change. Requests need not stay asserted until granted.
- hold asserted mid-stream: no new grants; already-issued accesses still complete and respond.
- Reset mid-operation: all in-flight responses are dropped; no rsp_valid until a new accept after release.
- busy = rom_en | OR of tag pipeline valids.

Optional Feature:
- Macro: SPRITE_ARB_LOCK_EN.
- With the macro defined:
  - Adds input req_lock (NREQ). An accept with req_lock[i]=1 starts a burst.
  - During a burst, requester i keeps priority over all others while req[i]=1 and hold=0.
  - The burst ends after 32 consecutive grants (one sprite row; 5-bit counter), or on the first cycle req[i]=0 or req_lock[i]=0.
  - On burst end ptr=i, so normal round-robin resumes after i.
  - hold pauses a burst without ending it or changing the count. Reset clears the burst.
- Without the macro: no req_lock port; pure round-robin.

Test Plan:
- Reset then req=3'b111 held, hold=0 → gnt sequence 001,010,100,001,...; rsp_id 0,1,2,0 starting 3 cycles after first gnt; rsp_valid continuously high.
- Single requester 1, addr=10'd33, img=1, ROM model returns addr[3:0] → rom_addr=33 at T+1, rsp_data=4'h1, rsp_id=1 at T+3.
- req_img=5'd7 on requester 2 → granted, rsp_bad=1, rsp_data=0.
- hold=1 for 4 cycles with req=3'b101 and 2 accesses in flight → gnt=0 for those cycles, both responses still arrive, busy falls to 0, then grants resume after ptr.
- Assert reset_n=0 one cycle after an accept → rsp_valid never asserts for that access; first grant after release goes to requester 0.
- SPRITE_ARB_LOCK_EN: requester 2 locked, req=3'b111 → 32 consecutive grants to 2, then 0,1,2 round-robin; dropping req_lock[2] at grant 10 ends the burst at 10.
